// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward sequencer for the 5-stage MIPS pipe, with MDU hold FSM.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_mdu_start_i,
  input  logic             ex_br_taken_i,
  input  logic             id_jump_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             wb_regwrite_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN, MDU_WAIT, MDU_DONE} state_t;
  localparam logic [3:0] WAIT_CYC = 4'(MDU_LAT - 2);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    return (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == r) ? 2'b10 :
           (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == r) ? 2'b01 : 2'b00;
  endfunction
  assign fwd_a_o  = reset_i ? 2'b00 : fwd_sel(ex_rs_i);
  assign fwd_b_o  = reset_i ? 2'b00 : fwd_sel(ex_rt_i);
  assign load_use = ex_memread_i && ex_rd_i != '0 &&
                    ((id_use_rs_i && id_rs_i == ex_rd_i) || (id_use_rt_i && id_rt_i == ex_rd_i));
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt holds the number of MDU_WAIT cycles still to go; MDU_LAT==2 skips MDU_WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (!ex_br_taken_i && ex_mdu_start_i) begin
        state_d = (WAIT_CYC == '0) ? MDU_DONE : MDU_WAIT;
        cnt_d   = WAIT_CYC;
      end
      MDU_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? MDU_DONE : MDU_WAIT;
      end
      MDU_DONE: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end
  always_comb begin
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    mdu_done_o   = 1'b0;
    if (reset_i) begin
      {pc_en_o, ifid_en_o, idex_en_o} = 3'b000;
      {ifid_flush_o, idex_flush_o}    = 2'b11;
    end else if (state_q == MDU_WAIT) begin
      {pc_en_o, ifid_en_o, idex_en_o} = 3'b000;
    end else if (state_q == MDU_DONE) begin
      mdu_done_o = 1'b1;
    end else if (ex_br_taken_i) begin
      {ifid_flush_o, idex_flush_o} = 2'b11;
    end else if (ex_mdu_start_i) begin
      {pc_en_o, ifid_en_o, idex_en_o} = 3'b000;
    end else if (load_use) begin
      {pc_en_o, ifid_en_o} = 2'b00;
      idex_flush_o         = 1'b1;
    end else if (id_jump_i) begin
      ifid_flush_o = 1'b1;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic             redirect;
  logic [CNT_W-1:0] stall_q, flush_q;
  // load-use bubbles are stalls, not redirects, so they never bump flush_cnt
  assign redirect = state_q == RUN && (ex_br_taken_i || (id_jump_i && !ex_mdu_start_i && !load_use));
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(!pc_en_o);
      flush_q <= flush_q + CNT_W'(redirect);
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, MDU/reset sequences and random run against a cycle-level model.
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic use_rs, use_rt, memread, mdu, br, jump, mem_rw, wb_rw;
  } in_t;
  typedef struct {
    string       nm;
    in_t         x;
    logic [9:0]  exp;
  } vec_t;
  localparam logic [9:0] RST_O  = 10'b000_11_00_00_0;
  localparam logic [9:0] IDLE_O = 10'b111_00_00_00_0;
  localparam logic [9:0] HOLD_O = 10'b000_00_00_00_0;
  localparam logic [9:0] DONE_O = 10'b111_00_00_00_1;
  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mdu_done;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic [9:0] outs;
  int checks = 0, passed = 0;
  int k = 0;
  bit cnt_ok = 0;
  int unsigned m_stall = 0, m_flush = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(rst),
    .id_rs_i(cur.id_rs), .id_rt_i(cur.id_rt), .id_use_rs_i(cur.use_rs), .id_use_rt_i(cur.use_rt),
    .ex_rs_i(cur.ex_rs), .ex_rt_i(cur.ex_rt), .ex_rd_i(cur.ex_rd), .ex_memread_i(cur.memread),
    .ex_mdu_start_i(cur.mdu), .ex_br_taken_i(cur.br), .id_jump_i(cur.jump),
    .mem_rd_i(cur.mem_rd), .wb_rd_i(cur.wb_rd), .mem_regwrite_i(cur.mem_rw), .wb_regwrite_i(cur.wb_rw),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mdu_done_o(mdu_done),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
  assign outs = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, fwd_a, fwd_b, mdu_done};
  // k = cycles elapsed since the MDU op started (0 = not busy); bit 10 flags a redirect
  function automatic logic [10:0] ref_out(in_t x, logic r, int kk);
    logic [1:0] fa, fb;
    logic lu;
    fa = (x.mem_rw && x.mem_rd != 0 && x.mem_rd == x.ex_rs) ? 2'b10 :
         (x.wb_rw && x.wb_rd != 0 && x.wb_rd == x.ex_rs) ? 2'b01 : 2'b00;
    fb = (x.mem_rw && x.mem_rd != 0 && x.mem_rd == x.ex_rt) ? 2'b10 :
         (x.wb_rw && x.wb_rd != 0 && x.wb_rd == x.ex_rt) ? 2'b01 : 2'b00;
    lu = x.memread && x.ex_rd != 0 && ((x.use_rs && x.id_rs == x.ex_rd) || (x.use_rt && x.id_rt == x.ex_rd));
    if (r) return {1'b0, RST_O};
    if (kk == LAT - 1) return {1'b0, 5'b111_00, fa, fb, 1'b1};
    if (kk > 0) return {1'b0, 5'b000_00, fa, fb, 1'b0};
    if (x.br) return {1'b1, 5'b111_11, fa, fb, 1'b0};
    if (x.mdu) return {1'b0, 5'b000_00, fa, fb, 1'b0};
    if (lu) return {1'b0, 5'b001_01, fa, fb, 1'b0};
    if (x.jump) return {1'b1, 5'b111_10, fa, fb, 1'b0};
    return {1'b0, 5'b111_00, fa, fb, 1'b0};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
  endtask
  task automatic drive(in_t x, logic r);
    cur = x;
    rst = r;
    @(negedge clk);
  endtask
  task automatic chk_model(string nm);
    logic [10:0] e;
    e = ref_out(cur, rst, k);
    chk({nm, " model outs"}, 32'(outs), 32'(e[9:0]));
    if (cnt_ok) begin
      chk({nm, " stall_cnt"}, stall_cnt, PERF ? m_stall : 0);
      chk({nm, " flush_cnt"}, flush_cnt, PERF ? m_flush : 0);
    end
  endtask
  task automatic adv();
    logic [10:0] e;
    e = ref_out(cur, rst, k);
    if (rst) begin
      k = 0; m_stall = 0; m_flush = 0; cnt_ok = 1;
    end else begin
      m_stall += 32'(!e[9]);
      m_flush += 32'(e[10]);
      if (k > 0) k = (k == LAT - 1) ? 0 : k + 1;
      else if (!cur.br && cur.mdu) k = 1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic step(string nm, in_t x, logic r, logic [9:0] exp);
    drive(x, r);
    chk(nm, 32'(outs), 32'(exp));
    chk_model(nm);
    adv();
  endtask
  function automatic in_t rnd_in();
    in_t x;
    x = '0;
    x.id_rs = 5'($urandom_range(0, 3)); x.id_rt = 5'($urandom_range(0, 3));
    x.ex_rs = 5'($urandom_range(0, 3)); x.ex_rt = 5'($urandom_range(0, 3));
    x.ex_rd = 5'($urandom_range(0, 3)); x.mem_rd = 5'($urandom_range(0, 3));
    x.wb_rd = 5'($urandom_range(0, 3));
    x.use_rs = 1'($urandom_range(0, 1)); x.use_rt = 1'($urandom_range(0, 1));
    x.memread = ($urandom_range(0, 2) == 0); x.mdu = ($urandom_range(0, 9) == 0);
    x.br = ($urandom_range(0, 7) == 0); x.jump = ($urandom_range(0, 7) == 0);
    x.mem_rw = 1'($urandom_range(0, 1)); x.wb_rw = 1'($urandom_range(0, 1));
    return x;
  endfunction
  initial begin
    in_t z, lu;
    z = '0;
    lu = '{id_rs: 5'd2, use_rs: 1'b1, ex_rd: 5'd2, memread: 1'b1, default: '0};
    tv.push_back('{"idle", z, IDLE_O});
    tv.push_back('{"fwd_a mem", '{ex_rs: 5'd5, mem_rd: 5'd5, wb_rd: 5'd5, mem_rw: 1'b1, wb_rw: 1'b1, default: '0}, 10'b111_00_10_00_0});
    tv.push_back('{"fwd_a wb", '{ex_rs: 5'd5, mem_rd: 5'd5, wb_rd: 5'd5, wb_rw: 1'b1, default: '0}, 10'b111_00_01_00_0});
    tv.push_back('{"fwd r0", '{mem_rw: 1'b1, wb_rw: 1'b1, default: '0}, IDLE_O});
    tv.push_back('{"fwd_b mem", '{ex_rt: 5'd7, mem_rd: 5'd7, mem_rw: 1'b1, default: '0}, 10'b111_00_00_10_0});
    tv.push_back('{"fwd a wb b mem", '{ex_rs: 5'd3, wb_rd: 5'd3, wb_rw: 1'b1, ex_rt: 5'd4, mem_rd: 5'd4, mem_rw: 1'b1, default: '0}, 10'b111_00_01_10_0});
    tv.push_back('{"load-use rs", lu, 10'b001_01_00_00_0});
    tv.push_back('{"load-use rt", '{id_rt: 5'd9, use_rt: 1'b1, ex_rd: 5'd9, memread: 1'b1, default: '0}, 10'b001_01_00_00_0});
    tv.push_back('{"load no use", '{id_rs: 5'd2, ex_rd: 5'd2, memread: 1'b1, default: '0}, IDLE_O});
    tv.push_back('{"load r0", '{use_rs: 1'b1, memread: 1'b1, default: '0}, IDLE_O});
    tv.push_back('{"branch+lu", '{id_rs: 5'd2, use_rs: 1'b1, ex_rd: 5'd2, memread: 1'b1, br: 1'b1, default: '0}, 10'b111_11_00_00_0});
    tv.push_back('{"jump", '{jump: 1'b1, default: '0}, 10'b111_10_00_00_0});
    tv.push_back('{"jump+lu", '{id_rs: 5'd2, use_rs: 1'b1, ex_rd: 5'd2, memread: 1'b1, jump: 1'b1, default: '0}, 10'b001_01_00_00_0});
    cur = z;
    rst = 1'b1;
    drive(z, 1'b1);
    chk("reset outs", 32'(outs), 32'(RST_O));
    adv();
    step("reset 2", z, 1'b1, RST_O);
    foreach (tv[i]) step(tv[i].nm, tv[i].x, 1'b0, tv[i].exp);
    step("lu stall", lu, 1'b0, 10'b001_01_00_00_0);
    step("lu fwd", '{ex_rs: 5'd2, mem_rd: 5'd2, mem_rw: 1'b1, default: '0}, 1'b0, 10'b111_00_10_00_0);
    step("mdu start", '{mdu: 1'b1, default: '0}, 1'b0, HOLD_O);
    step("mdu wait1", '{mdu: 1'b1, br: 1'b1, jump: 1'b1, default: '0}, 1'b0, HOLD_O);
    step("mdu wait2", '{mdu: 1'b1, br: 1'b1, jump: 1'b1, default: '0}, 1'b0, HOLD_O);
    step("mdu done", '{mdu: 1'b1, default: '0}, 1'b0, DONE_O);
    step("mdu after", z, 1'b0, IDLE_O);
    step("abort start", '{mdu: 1'b1, default: '0}, 1'b0, HOLD_O);
    step("abort wait1", z, 1'b0, HOLD_O);
    step("abort rst", z, 1'b1, RST_O);
    step("abort run", z, 1'b0, IDLE_O);
    step("abort no done", z, 1'b0, IDLE_O);
    step("perf rst", z, 1'b1, RST_O);
    step("perf lu1", lu, 1'b0, 10'b001_01_00_00_0);
    step("perf lu2", lu, 1'b0, 10'b001_01_00_00_0);
    step("perf br", '{br: 1'b1, default: '0}, 1'b0, 10'b111_11_00_00_0);
    drive(z, 1'b0);
    chk("perf stall_cnt", stall_cnt, PERF ? 32'd2 : 32'd0);
    chk("perf flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    adv();
    for (int i = 0; i < 3000; i++) begin
      drive(rnd_in(), $urandom_range(0, 39) == 0);
      chk_model("random");
      adv();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
